// File: rtl/trigger_pkg.sv
// Shared types and limits for the trigger conditioning blocks.
//   debounce_state_t : debounce FSM states
//   SYNC_STAGES_MIN/MAX, STABLE_CYCLES_MIN : legal parameter bounds
package trigger_pkg;

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_WAIT_LOW  = 2'd3
  } debounce_state_t;

  localparam int SYNC_STAGES_MIN   = 2;
  localparam int SYNC_STAGES_MAX   = 4;
  localparam int STABLE_CYCLES_MIN = 2;

endpackage

// File: rtl/trigger_sync_module.sv
// N-flop level synchronizer for an asynchronous single-bit input.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, clears every stage to 0
//   d   : asynchronous level in
//   q   : d delayed by STAGES clock edges
module trigger_sync_module
  import trigger_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
      assert (STAGES >= SYNC_STAGES_MIN && STAGES <= SYNC_STAGES_MAX);
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/trigger_debounce_module.sv
// Debounce stage in front of the D trigger: synchronizes raw level d,
// qualifies each change for STABLE_CYCLES consecutive synchronized
// samples, and presents a clean level q with one-cycle rise/fall strobes.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   d    : raw asynchronous level
//   q    : debounced level
//   rise : one-cycle pulse on the first cycle of q=1
//   fall : one-cycle pulse on the first cycle of q=0
//   busy : a candidate transition is being qualified
//   tq   : push-on/push-off level, flips with every rise
//          (only when TRIGGER_DEBOUNCE_TOGGLE_EN is defined)
module trigger_debounce_module
  import trigger_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall,
  output logic busy
`ifdef TRIGGER_DEBOUNCE_TOGGLE_EN
  ,output logic tq
`endif
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  // Count value seen on the last qualifying sample; the WAIT state is
  // entered with cnt=1 already covering the first new sample.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic            d_sync;
  debounce_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic            rise_nxt, fall_nxt;

  trigger_sync_module #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .q   (d_sync)
  );

  // State register; strobes are registered so they line up with the
  // first cycle of the new q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LOW;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
      assert (cnt <= CNT_LAST);
      assert (STABLE_CYCLES >= STABLE_CYCLES_MIN);
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      S_LOW: begin
        if (d_sync) begin
          state_nxt = S_WAIT_HIGH;
          cnt_nxt   = CNT_W'(1);
        end
      end
      S_WAIT_HIGH: begin
        if (!d_sync) begin
          state_nxt = S_LOW;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_HIGH;
          cnt_nxt   = '0;
          rise_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_HIGH: begin
        if (!d_sync) begin
          state_nxt = S_WAIT_LOW;
          cnt_nxt   = CNT_W'(1);
        end
      end
      S_WAIT_LOW: begin
        if (d_sync) begin
          state_nxt = S_HIGH;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = S_LOW;
          cnt_nxt   = '0;
          fall_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = S_LOW;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode from the state register only (no path from d)
  always_comb begin
    q    = (state == S_HIGH) || (state == S_WAIT_LOW);
    busy = (state == S_WAIT_HIGH) || (state == S_WAIT_LOW);
  end

`ifdef TRIGGER_DEBOUNCE_TOGGLE_EN
  always_ff @(posedge clk) begin
    if (rst)           tq <= 1'b0;
    else if (rise_nxt) tq <= ~tq;
  end
`endif

endmodule

// File: tb/tb_trigger_debounce_module.sv
// Self-checking bench for trigger_debounce_module (default parameters).
// Reference model: a level is accepted once STABLE consecutive
// synchronized samples differ from the current output level.
module tb_trigger_debounce_module;

  localparam int SYNC   = 2;
  localparam int STABLE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic d   = 1'b0;
  logic q, rise, fall, busy;
`ifdef TRIGGER_DEBOUNCE_TOGGLE_EN
  logic tq;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // model state
  logic [SYNC-1:0] m_pipe = '0;
  logic m_q = 0, m_rise = 0, m_fall = 0, m_busy = 0, m_tq = 0;
  int   m_run = 0;

  always #5 clk = ~clk;

  trigger_debounce_module #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE)) dut (
    .clk  (clk),
    .rst  (rst),
    .d    (d),
    .q    (q),
    .rise (rise),
    .fall (fall),
    .busy (busy)
`ifdef TRIGGER_DEBOUNCE_TOGGLE_EN
    ,.tq  (tq)
`endif
  );

  // Drive one edge and advance the model; outputs are sampled 1ns later.
  task automatic step(input logic dv, input logic rv);
    logic ds;
    d   = dv;
    rst = rv;
    @(posedge clk);
    m_rise = 0;
    m_fall = 0;
    if (rv) begin
      m_pipe = '0; m_q = 0; m_run = 0; m_busy = 0; m_tq = 0;
    end else begin
      ds     = m_pipe[SYNC-1];
      m_pipe = {m_pipe[SYNC-2:0], dv};
      if (ds != m_q) m_run++;
      else           m_run = 0;
      if (m_run == STABLE) begin
        m_q   = ~m_q;
        m_run = 0;
        if (m_q) begin m_rise = 1; m_tq = ~m_tq; end
        else     m_fall = 1;
      end
      m_busy = (m_run != 0);
    end
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1);
      n_tests++;
      if ({q, rise, fall, busy} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_outputs edge %0d: got q/rise/fall/busy=%b want 0000", k, {q, rise, fall, busy});
      end
    end
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b0);
      n_tests++;
      if (rise !== (k == 6)) begin
        n_fail++;
        $display("FAIL reset_release_rise edge %0d: got %b want %b", k, rise, (k == 6));
      end
    end
  endtask

  task automatic test_clean_rise();
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b0);
      n_tests++;
      if (busy !== (k >= 3 && k <= 5)) begin
        n_fail++;
        $display("FAIL rise_busy edge %0d: got %b want %b", k, busy, (k >= 3 && k <= 5));
      end
      n_tests++;
      if (q !== (k >= 6) || rise !== (k == 6) || fall !== 1'b0) begin
        n_fail++;
        $display("FAIL rise_q_strobe edge %0d: got q=%b rise=%b fall=%b want q=%b rise=%b fall=0",
                 k, q, rise, fall, (k >= 6), (k == 6));
      end
    end
  endtask

  task automatic test_bounce();
    logic [11:0] pat;
    pat = 12'b000000011011;  // bit 0 first: 1,1,0,1,1,0...
    step(1'b0, 1'b1);
    for (int k = 0; k < 12; k++) begin
      step(pat[k], 1'b0);
      n_tests++;
      if (q !== 1'b0 || rise !== 1'b0) begin
        n_fail++;
        $display("FAIL bounce_q edge %0d: got q=%b rise=%b want 0 0", k, q, rise);
      end
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_busy_idle: got %b want 0", busy);
    end
  endtask

  task automatic test_clean_fall();
    step(1'b0, 1'b1);
    for (int k = 0; k < 8; k++) step(1'b1, 1'b0);
    n_tests++;
    if (q !== 1'b1) begin
      n_fail++;
      $display("FAIL fall_setup_q: got %b want 1", q);
    end
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 1'b0);
      n_tests++;
      if (q !== (k < 6) || fall !== (k == 6) || rise !== 1'b0) begin
        n_fail++;
        $display("FAIL fall_q_strobe edge %0d: got q=%b fall=%b rise=%b want q=%b fall=%b rise=0",
                 k, q, fall, rise, (k < 6), (k == 6));
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b1);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_busy_before: got %b want 1", busy);
    end
    step(1'b1, 1'b1);
    n_tests++;
    if ({q, rise, fall, busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midrst_outputs: got q/rise/fall/busy=%b want 0000", {q, rise, fall, busy});
    end
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b0);
      n_tests++;
      if (q !== (k >= 6) || rise !== (k == 6)) begin
        n_fail++;
        $display("FAIL midrst_restart edge %0d: got q=%b rise=%b want q=%b rise=%b",
                 k, q, rise, (k >= 6), (k == 6));
      end
    end
  endtask

  task automatic test_random();
    logic dv, rv;
    int   seg;
    step(1'b0, 1'b1);
    seg = 0;
    dv  = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (seg == 0) begin
        dv  = ~dv;
        seg = $urandom_range(1, 8);
      end
      seg--;
      rv = ($urandom_range(0, 63) == 0);
      step(dv, rv);
      n_tests++;
      if (q !== m_q || rise !== m_rise || fall !== m_fall || busy !== m_busy) begin
        n_fail++;
        $display("FAIL random edge %0d: got q/rise/fall/busy=%b%b%b%b want %b%b%b%b",
                 k, q, rise, fall, busy, m_q, m_rise, m_fall, m_busy);
      end
      n_tests++;
      if (rise && fall) begin
        n_fail++;
        $display("FAIL random_strobe_overlap edge %0d: got rise=1 fall=1 want not both", k);
      end
    end
  endtask

`ifdef TRIGGER_DEBOUNCE_TOGGLE_EN
  task automatic test_toggle();
    int presses;
    logic exp_tq;
    presses = 0;
    exp_tq  = 1'b0;
    step(1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 20; k++) begin
        step((k < 10), 1'b0);
        if (rise) begin
          presses++;
          exp_tq = (presses % 2) == 1;
        end
        n_tests++;
        if (tq !== exp_tq || tq !== m_tq) begin
          n_fail++;
          $display("FAIL toggle_tq cycle %0d edge %0d: got %b want %b", c, k, tq, exp_tq);
        end
      end
    end
    n_tests++;
    if (presses != 3) begin
      n_fail++;
      $display("FAIL toggle_press_count: got %0d want 3", presses);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_rise();
    test_bounce();
    test_clean_fall();
    test_reset_mid();
    test_random();
`ifdef TRIGGER_DEBOUNCE_TOGGLE_EN
    test_toggle();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
